// File: rtl/div_seq.sv
// div_seq: iterative restoring divider, 2W-bit dividend by W-bit divisor,
// one quotient bit per clock. It is started by the microsequencer for the
// divide instruction, and its results go back to the register file.
//
// Ports (vectors are numbered with bit 0 = MSB):
//   clk_sys      system clock, rising edge
//   clr          asynchronous active-high reset; aborts any operation in flight
//   start        one-cycle request; only sampled in IDLE
//   sgn          1 = two's complement operands (only when SIGNED_EN=1)
//   dvd [0:2W-1] dividend, captured on an accepted start
//   dvs [0:W-1]  divisor, captured on an accepted start
//   q, r         quotient / remainder; updated only by a successful divide
//   busy         high from the cycle after an accepted start through the done cycle
//   done         one-cycle completion pulse; q/r/flags are valid from this cycle
//   ovf, dz      quotient overflow / divide by zero; held until the next operation
//   zero_        active-low; 0 when a successful divide produced q == 0
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | take operand magnitudes, screen for divide-by-zero and overflow
// ITER  | 16 trial-subtract/shift steps; the last step also applies signs
// DONE  | done pulse, then back to IDLE
//
// The sign fix-up is folded into the edge that closes the last ITER step,
// so results land together with done: done is N+18 after a start sampled
// in cycle N, and N+2 when LOAD rejects the operands.

module div_seq #(
   parameter int W         = 16,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic           clk_sys,
   input  logic           clr,
   input  logic           start,
   input  logic           sgn,
   input  logic [0:2*W-1] dvd,
   input  logic [0:W-1]   dvs,
   output logic [0:W-1]   q,
   output logic [0:W-1]   r,
   output logic           busy,
   output logic           done,
   output logic           ovf,
   output logic           dz,
   output logic           zero_
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);
   localparam logic [W-1:0]  HALF = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

   state_t          state_q, state_d;
   logic [2*W-1:0]  dvd_q, dvd_d;
   logic [W-1:0]    dvs_q, dvs_d;
   logic            sgn_q, sgn_d;
   logic [W-1:0]    dvsm_q, dvsm_d;
   logic [W-1:0]    part_q, part_d;
   logic [W-1:0]    lo_q, lo_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic [W-1:0]    q_q, q_d;
   logic [W-1:0]    r_q, r_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            ovf_q, ovf_d;
   logic            dz_q, dz_d;
   logic            zero_n_q, zero_n_d;

   logic            signed_op;
   logic            dvd_neg, dvs_neg;
   logic [2*W-1:0]  dvd_mag;
   logic [W-1:0]    dvs_mag;
   logic [W:0]      shifted, trial;
   logic            qbit;
   logic [W-1:0]    part_nx, lo_nx;
   logic            sovf;

   assign signed_op = SIGNED_EN && sgn_q;
   assign dvd_neg   = signed_op && dvd_q[2*W-1];
   assign dvs_neg   = signed_op && dvs_q[W-1];
   assign dvd_mag   = dvd_neg ? -dvd_q : dvd_q;
   assign dvs_mag   = dvs_neg ? -dvs_q : dvs_q;

   // One restoring step: no borrow means the divisor fits, keep the difference.
   assign shifted = {part_q, lo_q[W-1]};
   assign trial   = shifted - {1'b0, dvsm_q};
   assign qbit    = ~trial[W];
   assign part_nx = qbit ? trial[W-1:0] : shifted[W-1:0];
   assign lo_nx   = {lo_q[W-2:0], qbit};

   // A negative result may reach -2^(W-1); a positive one must stay below 2^(W-1).
   assign sovf = signed_op && (qneg_q ? (lo_nx > HALF) : lo_nx[W-1]);

   always_comb begin
      state_d  = state_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      sgn_d    = sgn_q;
      dvsm_d   = dvsm_q;
      part_d   = part_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      q_d      = q_q;
      r_d      = r_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      ovf_d    = ovf_q;
      dz_d     = dz_q;
      zero_n_d = zero_n_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               dvd_d   = dvd;
               dvs_d   = dvs;
               sgn_d   = sgn;
               busy_d  = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            zero_n_d = 1'b1;
            if (dvs_q == '0) begin
               dz_d    = 1'b1;
               ovf_d   = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end else if (dvd_mag[2*W-1:W] >= dvs_mag) begin
               dz_d    = 1'b0;
               ovf_d   = 1'b1;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               dz_d    = 1'b0;
               ovf_d   = 1'b0;
               dvsm_d  = dvs_mag;
               part_d  = dvd_mag[2*W-1:W];
               lo_d    = dvd_mag[W-1:0];
               qneg_d  = dvd_neg ^ dvs_neg;
               rneg_d  = dvd_neg;
               cnt_d   = '0;
               state_d = ITER;
            end
         end
         ITER: begin
            part_d = part_nx;
            lo_d   = lo_nx;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               if (sovf) begin
                  ovf_d = 1'b1;
               end else begin
                  q_d      = qneg_q ? -lo_nx : lo_nx;
                  r_d      = rneg_q ? -part_nx : part_nx;
                  zero_n_d = (lo_nx != '0);
               end
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge clr) begin
      if (clr) begin
         state_q  <= IDLE;
         dvd_q    <= '0;
         dvs_q    <= '0;
         sgn_q    <= 1'b0;
         dvsm_q   <= '0;
         part_q   <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         q_q      <= '0;
         r_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         dz_q     <= 1'b0;
         zero_n_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         sgn_q    <= sgn_d;
         dvsm_q   <= dvsm_d;
         part_q   <= part_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         q_q      <= q_d;
         r_q      <= r_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
         dz_q     <= dz_d;
         zero_n_q <= zero_n_d;
      end
   end

   assign q     = q_q;
   assign r     = r_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign ovf   = ovf_q;
   assign dz    = dz_q;
   assign zero_ = zero_n_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: hand-computed quotient/remainder/flags,
// done latency counted in cycles after the start cycle, busy window,
// ignored start while busy, and clr abort mid-operation.

module tb_div_seq;

   logic        clk_sys = 1'b0;
   logic        clr     = 1'b1;
   logic        start   = 1'b0;
   logic        sgn     = 1'b0;
   logic [0:31] dvd     = '0;
   logic [0:15] dvs     = '0;
   logic [0:15] q, r;
   logic        busy, done, ovf, dz, zero_;

   int n_chk = 0;
   int n_err = 0;

   div_seq #(.W(16), .SIGNED_EN(1'b1)) dut (
      .clk_sys (clk_sys),
      .clr     (clr),
      .start   (start),
      .sgn     (sgn),
      .dvd     (dvd),
      .dvs     (dvs),
      .q       (q),
      .r       (r),
      .busy    (busy),
      .done    (done),
      .ovf     (ovf),
      .dz      (dz),
      .zero_   (zero_)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Start in cycle N, then watch cycles N+1..N+40 at the falling edge.
   // restart_at > 0 pulses a second start in that cycle.
   task automatic run_op(input logic [31:0] a, input logic [15:0] b, input logic s,
                         input int restart_at,
                         output int lat, output int npulse,
                         output logic busy_first, output logic busy_at_done,
                         output logic busy_after);
      @(negedge clk_sys);
      dvd = a; dvs = b; sgn = s; start = 1'b1;
      lat = -1; npulse = 0;
      busy_first = 1'b0; busy_at_done = 1'b0; busy_after = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk_sys);
         start = (k == restart_at);
         if (k == 1) busy_first = busy;
         if (lat > 0 && k == lat + 1) busy_after = busy;
         if (done) begin
            npulse++;
            if (lat < 0) begin
               lat = k;
               busy_at_done = busy;
            end
         end
      end
      start = 1'b0;
   endtask

   task automatic check_res(input string tag, input int lat, input int exp_lat,
                            input int npulse,
                            input logic [15:0] eq, input logic [15:0] er,
                            input logic eovf, input logic edz, input logic ezero_n);
      chk({tag, ".lat"},   32'(lat),    32'(exp_lat));
      chk({tag, ".pulse"}, 32'(npulse), 32'd1);
      chk({tag, ".q"},     32'(q),      32'(eq));
      chk({tag, ".r"},     32'(r),      32'(er));
      chk({tag, ".ovf"},   32'(ovf),    32'(eovf));
      chk({tag, ".dz"},    32'(dz),     32'(edz));
      chk({tag, ".zero_"}, 32'(zero_),  32'(ezero_n));
   endtask

   initial begin
      int   lat, np;
      logic b1, bd, ba;

      #12;
      chk("rst.q",     32'(q),     32'h0);
      chk("rst.r",     32'(r),     32'h0);
      chk("rst.busy",  32'(busy),  32'h0);
      chk("rst.done",  32'(done),  32'h0);
      chk("rst.ovf",   32'(ovf),   32'h0);
      chk("rst.dz",    32'(dz),    32'h0);
      chk("rst.zero_", 32'(zero_), 32'h1);
      @(negedge clk_sys);
      clr = 1'b0;
      repeat (2) @(negedge clk_sys);

      // unsigned basic: 100 / 7 = 14 r 2
      run_op(32'h0000_0064, 16'h0007, 1'b0, 0, lat, np, b1, bd, ba);
      check_res("u_basic", lat, 18, np, 16'h000E, 16'h0002, 1'b0, 1'b0, 1'b1);
      chk("u_basic.busy1",    32'(b1), 32'h1);
      chk("u_basic.busydone", 32'(bd), 32'h1);
      chk("u_basic.busyaft",  32'(ba), 32'h0);

      // divide by zero: q/r hold previous result
      run_op(32'h0000_1234, 16'h0000, 1'b0, 0, lat, np, b1, bd, ba);
      check_res("dz", lat, 2, np, 16'h000E, 16'h0002, 1'b0, 1'b1, 1'b1);
      chk("dz.busy1",    32'(b1), 32'h1);
      chk("dz.busydone", 32'(bd), 32'h1);
      chk("dz.busyaft",  32'(ba), 32'h0);

      // unsigned overflow: hi word 7 >= 7
      run_op(32'h0007_0000, 16'h0007, 1'b0, 0, lat, np, b1, bd, ba);
      check_res("u_ovf", lat, 2, np, 16'h000E, 16'h0002, 1'b1, 1'b0, 1'b1);

      // largest quotient that still fits: 0x6FFFF / 7 = 0xFFFF r 6
      run_op(32'h0006_FFFF, 16'h0007, 1'b0, 0, lat, np, b1, bd, ba);
      check_res("u_edge", lat, 18, np, 16'hFFFF, 16'h0006, 1'b0, 1'b0, 1'b1);

      // unsigned mode treats 0xFF9C as 65436: 65436 / 7 = 9348 r 0
      run_op(32'h0000_FF9C, 16'h0007, 1'b0, 0, lat, np, b1, bd, ba);
      check_res("u_raw", lat, 18, np, 16'h2484, 16'h0000, 1'b0, 1'b0, 1'b1);

      // signed: -100 / 7 = -14 r -2
      run_op(32'hFFFF_FF9C, 16'h0007, 1'b1, 0, lat, np, b1, bd, ba);
      check_res("s_neg", lat, 18, np, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 1'b1);

      // signed: 32768 / 1 = +32768 does not fit; q/r hold -14/-2
      run_op(32'h0000_8000, 16'h0001, 1'b1, 0, lat, np, b1, bd, ba);
      check_res("s_ovf", lat, 18, np, 16'hFFF2, 16'hFFFE, 1'b1, 1'b0, 1'b1);

      // signed: -32768 / 1 = -32768 fits
      run_op(32'hFFFF_8000, 16'h0001, 1'b1, 0, lat, np, b1, bd, ba);
      check_res("s_min", lat, 18, np, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1);

      // signed: 100 / -7 = -14 r 2 (remainder follows dividend sign)
      run_op(32'h0000_0064, 16'hFFF9, 1'b1, 0, lat, np, b1, bd, ba);
      check_res("s_dvsneg", lat, 18, np, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 1'b1);

      // signed: 32768 / -1 = -32768 fits
      run_op(32'h0000_8000, 16'hFFFF, 1'b1, 0, lat, np, b1, bd, ba);
      check_res("s_m1", lat, 18, np, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1);

      // signed: 0x80000000 has hi magnitude 0x8000 >= 7 -> ovf in LOAD
      run_op(32'h8000_0000, 16'h0007, 1'b1, 0, lat, np, b1, bd, ba);
      check_res("s_big", lat, 2, np, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1);

      // zero quotient, second start at N+5 must be ignored
      run_op(32'h0000_0003, 16'h0009, 1'b0, 5, lat, np, b1, bd, ba);
      check_res("zq", lat, 18, np, 16'h0000, 16'h0003, 1'b0, 1'b0, 1'b0);

      // clr at N+9 aborts; no done afterwards
      @(negedge clk_sys);
      dvd = 32'h0000_0064; dvs = 16'h0007; sgn = 1'b0; start = 1'b1;
      @(negedge clk_sys);
      start = 1'b0;
      repeat (8) @(negedge clk_sys);
      clr = 1'b1;
      #1;
      chk("abort.busy",  32'(busy),  32'h0);
      chk("abort.q",     32'(q),     32'h0);
      chk("abort.r",     32'(r),     32'h0);
      chk("abort.zero_", 32'(zero_), 32'h1);
      @(negedge clk_sys);
      clr = 1'b0;
      np = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk_sys);
         if (done) np++;
      end
      chk("abort.nodone", 32'(np), 32'h0);

      run_op(32'h0000_0064, 16'h0007, 1'b0, 0, lat, np, b1, bd, ba);
      check_res("post", lat, 18, np, 16'h000E, 16'h0002, 1'b0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
